// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank write-back slice.
package regbank_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 16;

    // One queued register-bank write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic                  high;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write requests. DEPTH must be a power of two,
// so the pointers wrap naturally. The count is one bit wider than a pointer.
// full/empty come from the registered count only, with no same-cycle bypass.
module wb_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t           mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regbank_writeback.sv
// Write-side controller for the 16x32 register bank: merges execute results
// and buffered load returns onto the single write port, and keeps a pending
// scoreboard for decode hazards.
// Optional macro REGBANK_WB_CHECK_EN enables the sticky wb_err protocol check.
module regbank_writeback
    import regbank_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0]     ex_data,
    input  logic                  ex_high,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic                  hazard,
    output logic [NUM_REGS-1:0]   pending,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_we,
    output logic                  wb_we_high,
    output logic                  wb_err
);

    logic          fifo_full;
    logic          fifo_empty;
    logic          mem_push;
    logic          fifo_pop;
    wb_req_t       fifo_in;
    wb_req_t       fifo_head;
    logic [NUM_REGS-1:0] pending_nxt;

    assign mem_ready = !fifo_full;
    assign mem_push  = mem_valid && !fifo_full;
    // Execute always owns the port; the queue drains only in free cycles.
    assign fifo_pop  = !ex_valid && !fifo_empty;

    // Loads are always full-word writes.
    assign fifo_in = '{addr: mem_addr, data: mem_data, high: 1'b0};

    wb_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Scoreboard update: clear on pop of the load's write, then a new issue wins.
    always_comb begin
        pending_nxt = pending;
        if (fifo_pop && (fifo_head.addr != '0)) begin
            pending_nxt[fifo_head.addr] = 1'b0;
        end
        if (ld_issue && (ld_addr != '0)) begin
            pending_nxt[ld_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Decode hazard; r0 is never a hazard, and the bank bypass covers the write cycle.
    assign hazard = ((rd_addr_a != '0) && pending[rd_addr_a]) ||
                    ((rd_addr_b != '0) && pending[rd_addr_b]);

    // Registered bank write port: execute first, else queue head, else idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_we      <= 1'b0;
            wb_we_high <= 1'b0;
        end else if (ex_valid) begin
            wb_addr    <= ex_addr;
            wb_data    <= ex_data;
            wb_we      <= (ex_addr != '0);
            wb_we_high <= ex_high;
        end else if (fifo_pop) begin
            wb_addr    <= fifo_head.addr;
            wb_data    <= fifo_head.data;
            wb_we      <= (fifo_head.addr != '0);
            wb_we_high <= fifo_head.high;
        end else begin
            wb_we      <= 1'b0;
            wb_we_high <= 1'b0;
        end
    end

`ifdef REGBANK_WB_CHECK_EN
    logic err_q;

    // Sticky error: WAW against an outstanding load, or a return nobody asked for.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((ex_valid && pending[ex_addr]) ||
                     (mem_push && (mem_addr != '0) && !pending[mem_addr])) begin
            err_q <= 1'b1;
        end
    end

    assign wb_err = err_q;
`else
    assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_regbank_writeback.sv
// Randomised and directed bench for regbank_writeback against a queue-based
// reference model of the write-back rules.
module tb_regbank_writeback;

    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [3:0]  ex_addr;
    logic [31:0] ex_data;
    logic        ex_high;
    logic        ld_issue;
    logic [3:0]  ld_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        hazard;
    logic [15:0] pending;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        wb_we_high;
    logic        wb_err;

    regbank_writeback #(.QDEPTH(QDEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_addr    (ex_addr),
        .ex_data    (ex_data),
        .ex_high    (ex_high),
        .ld_issue   (ld_issue),
        .ld_addr    (ld_addr),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .hazard     (hazard),
        .pending    (pending),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_we      (wb_we),
        .wb_we_high (wb_we_high),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit [15:0]   m_pend;
    logic [3:0]  q_addr [$];
    logic [31:0] q_data [$];
    bit          m_err;
    bit          e_we, e_high;
    logic [3:0]  e_addr;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_haz();
        return ((rd_addr_a != 0) && m_pend[rd_addr_a]) || ((rd_addr_b != 0) && m_pend[rd_addr_b]);
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_addr = 0; ex_data = 0; ex_high = 0;
        ld_issue = 0; ld_addr = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        rd_addr_a = 0; rd_addr_b = 0;
    endtask

    // Apply the currently driven inputs for one clock and check the result.
    task automatic step();
        bit [15:0] old_pend;
        bit        push;
        old_pend = m_pend;
        push = mem_valid && (q_addr.size() < QDEPTH);
        if (ex_valid) begin
            e_we = (ex_addr != 0); e_addr = ex_addr; e_data = ex_data; e_high = ex_high;
            if (old_pend[ex_addr]) m_err = 1;
        end else if (q_addr.size() > 0) begin
            e_addr = q_addr.pop_front();
            e_data = q_data.pop_front();
            e_we = (e_addr != 0); e_high = 0;
            if (e_addr != 0) m_pend[e_addr] = 0;
        end else begin
            e_we = 0; e_high = 0;
        end
        if (push) begin
            if (mem_addr != 0 && !old_pend[mem_addr]) m_err = 1;
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_data);
        end
        if (ld_issue && ld_addr != 0) m_pend[ld_addr] = 1;
        @(posedge clk);
        @(negedge clk);
        chk("wb_we", wb_we, e_we);
        chk("wb_we_high", wb_we_high, e_high);
        if (e_we) begin
            chk("wb_addr", wb_addr, e_addr);
            chk("wb_data", wb_data, e_data);
        end
        chk("pending", pending, m_pend);
        chk("mem_ready", mem_ready, q_addr.size() < QDEPTH);
        chk("hazard", hazard, exp_haz());
`ifdef REGBANK_WB_CHECK_EN
        chk("wb_err", wb_err, m_err);
`else
        chk("wb_err", wb_err, 0);
`endif
    endtask

    // Asynchronous reset: outputs must clear without a clock edge.
    task automatic do_reset();
        reset = 0;
        #1;
        chk("rst_we", wb_we, 0);
        chk("rst_we_high", wb_we_high, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_err", wb_err, 0);
        chk("rst_ready", mem_ready, 1);
        m_pend = 0; m_err = 0; e_we = 0; e_high = 0;
        q_addr.delete(); q_data.delete();
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        logic [3:0]  ret_a [3];
        logic [31:0] ret_d [3];
        logic [31:0] got_d [$];
        int ri;

        idle_inputs();
        reset = 1;
        #2;
        do_reset();

        // Execute write r5
        ex_valid = 1; ex_addr = 5; ex_data = 32'h12345678;
        step();
        chk("t1_we", wb_we, 1);
        chk("t1_addr", wb_addr, 5);
        chk("t1_data", wb_data, 32'h12345678);
        chk("t1_high", wb_we_high, 0);
        idle_inputs();

        // Load r3, hazard, return, clear
        ld_issue = 1; ld_addr = 3;
        step();
        idle_inputs();
        rd_addr_a = 3;
        #1;
        chk("t2_hazard_set", hazard, 1);
        mem_valid = 1; mem_addr = 3; mem_data = 32'hDEADBEEF;
        step();
        mem_valid = 0;
        chk("t2_no_we_yet", wb_we, 0);
        step();
        chk("t2_we", wb_we, 1);
        chk("t2_data", wb_data, 32'hDEADBEEF);
        chk("t2_pend3", pending[3], 0);
        chk("t2_hazard_clr", hazard, 0);
        idle_inputs();

        // Back-to-back returns while execute holds the port
        ret_a[0] = 1; ret_a[1] = 2; ret_a[2] = 6;
        ret_d[0] = 32'hA1A1A1A1; ret_d[1] = 32'hB2B2B2B2; ret_d[2] = 32'hC3C3C3C3;
        for (int i = 0; i < 3; i++) begin
            ld_issue = 1; ld_addr = ret_a[i];
            step();
        end
        idle_inputs();
        ri = 0;
        for (int k = 0; k < 5; k++) begin
            ex_valid = 1; ex_addr = 9; ex_data = k;
            if (k == 2) chk("t3_ready_low", mem_ready, 0);
            mem_valid = (ri < 3);
            if (ri < 3) begin mem_addr = ret_a[ri]; mem_data = ret_d[ri]; end
            if (ri < 3 && q_addr.size() < QDEPTH) begin
                step(); ri++;
            end else begin
                step();
            end
        end
        ex_valid = 0;
        for (int k = 0; k < 8; k++) begin
            mem_valid = (ri < 3);
            if (ri < 3) begin mem_addr = ret_a[ri]; mem_data = ret_d[ri]; end
            if (ri < 3 && q_addr.size() < QDEPTH) begin
                step(); ri++;
            end else begin
                step();
            end
            if (wb_we) got_d.push_back(wb_data);
        end
        idle_inputs();
        chk("t3_drained", got_d.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_order", (i < got_d.size()) ? got_d[i] : 32'hX, ret_d[i]);
        end

        // Load-high write
        ex_valid = 1; ex_addr = 7; ex_data = 32'h0000ABCD; ex_high = 1;
        step();
        chk("t4_we", wb_we, 1);
        chk("t4_high", wb_we_high, 1);
        chk("t4_low16", wb_data[15:0], 16'hABCD);
        idle_inputs();

        // r0 from both sources
        ex_valid = 1; ex_addr = 0; ex_data = 32'h11111111;
        ld_issue = 1; ld_addr = 0;
        step();
        chk("t5_ex_r0", wb_we, 0);
        idle_inputs();
        mem_valid = 1; mem_addr = 0; mem_data = 32'h22222222;
        step();
        idle_inputs();
        step();
        chk("t5_mem_r0", wb_we, 0);
        chk("t5_pend0", pending[0], 0);

        // WAW against an outstanding load
        ld_issue = 1; ld_addr = 4;
        step();
        idle_inputs();
        ex_valid = 1; ex_addr = 4; ex_data = 32'h44;
        step();
        idle_inputs();
`ifdef REGBANK_WB_CHECK_EN
        chk("t6_err", wb_err, 1);
`else
        chk("t6_err", wb_err, 0);
`endif
        step();
        step();
        do_reset();

        // Reset while a return is still queued
        ld_issue = 1; ld_addr = 8;
        step();
        idle_inputs();
        ex_valid = 1; ex_addr = 10; ex_data = 32'h5;
        mem_valid = 1; mem_addr = 8; mem_data = 32'h88888888;
        step();
        idle_inputs();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t7_no_stale_we", wb_we, 0);
        end

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            ex_valid  = ($urandom_range(0, 9) < 4);
            ex_addr   = 4'($urandom_range(0, 15));
            ex_data   = $urandom;
            ex_high   = 1'($urandom_range(0, 1));
            ld_issue  = ($urandom_range(0, 9) < 3);
            ld_addr   = 4'($urandom_range(0, 15));
            mem_valid = ($urandom_range(0, 9) < 4);
            mem_addr  = 4'($urandom_range(0, 15));
            mem_data  = $urandom;
            rd_addr_a = 4'($urandom_range(0, 15));
            rd_addr_b = 4'($urandom_range(0, 15));
            #1;
            chk("rnd_hazard_comb", hazard, exp_haz());
            step();
            if ($urandom_range(0, 99) == 0) begin
                idle_inputs();
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
